// File: rtl/uart_auto_baud_detect_pkg.sv
// Shared constants for the eUSCI_A auto-baud detector: FSM encodings,
// sync-field edge count and the second-stage modulation lookup.
package uart_auto_baud_detect_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_BRK = 3'd1;
   localparam logic [2:0] ST_BRK      = 3'd2;
   localparam logic [2:0] ST_DELIM    = 3'd3;
   localparam logic [2:0] ST_SYNC     = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   // Falling edges of 0x55 LSB-first, start bit included.
   localparam logic [2:0] SYNC_EDGES  = 3'd5;

   localparam logic [7:0] BRS_LUT_0 = 8'h00;
   localparam logic [7:0] BRS_LUT_1 = 8'h01;
   localparam logic [7:0] BRS_LUT_2 = 8'h11;
   localparam logic [7:0] BRS_LUT_3 = 8'h25;
   localparam logic [7:0] BRS_LUT_4 = 8'h55;
   localparam logic [7:0] BRS_LUT_5 = 8'h5B;
   localparam logic [7:0] BRS_LUT_6 = 8'h77;
   localparam logic [7:0] BRS_LUT_7 = 8'h7F;

   function automatic logic [7:0] brs_lookup(input logic [2:0] frac);
      logic [7:0] brs;
      case (frac)
         3'd0:    brs = BRS_LUT_0;
         3'd1:    brs = BRS_LUT_1;
         3'd2:    brs = BRS_LUT_2;
         3'd3:    brs = BRS_LUT_3;
         3'd4:    brs = BRS_LUT_4;
         3'd5:    brs = BRS_LUT_5;
         3'd6:    brs = BRS_LUT_6;
         default: brs = BRS_LUT_7;
      endcase
      return brs;
   endfunction

endpackage

// File: rtl/abd_divisor_calc.sv
// Combinational mapping from the 8-bit-time cycle count N to the eUSCI
// baud divisor fields, with an error flag for unusable prescalers.
module abd_divisor_calc
   import uart_auto_baud_detect_pkg::*;
#(
   parameter int CNT_W = 23
) (
   input  logic [CNT_W-1:0] n,
   input  logic             os16,
   output logic [15:0]      brx,
   output logic [3:0]       brfx,
   output logic [7:0]       brsx,
   output logic             err
);

   logic [CNT_W-1:0] quot;

   // N spans 8 bit times: /8 gives cycles per bit, /128 gives cycles per 16x sample.
   always_comb begin
      quot = os16 ? (n >> 7) : (n >> 3);
      brx  = quot[15:0];
      brfx = os16 ? n[6:3] : 4'd0;
      brsx = brs_lookup(n[2:0]);
      err  = (quot == '0) || (quot > CNT_W'(16'hFFFF));
   end

endmodule

// File: rtl/uart_auto_baud_detect.sv
// Auto-baud detector: measures break + 0x55 sync field on the RX pin in BRCLK
// cycles and produces matching UCBRx / UCBRFx / UCBRSx values.
//
//   state    | meaning
//   IDLE     | auto-baud disabled
//   WAIT_BRK | line watched for the falling edge that may start a break
//   BRK      | counting low time of a candidate break
//   DELIM    | counting high time between break and sync start bit
//   SYNC     | counting cycles across 8 bit times of the sync field
//   DONE     | new divisor registered, ABDDone high
module uart_auto_baud_detect
   import uart_auto_baud_detect_pkg::*;
#(
   parameter int CNT_W     = 23,
   parameter int BRK_MIN   = 1024,
   parameter int DELIM_MAX = 4096
) (
   input  logic        BRCLK,
   input  logic        reset,
   input  logic        UCABDEN,
   input  logic        UCRXD,
   output logic        UCBRKIFG,
   input  logic        UCBRKCLR,
   output logic        UCSTOE,
   input  logic        UCSTOECLR,
   output logic        ABDDone,
   output logic        ABDBusy,
   output logic [15:0] wABD_BRx,
   output logic [3:0]  wABD_BRFx,
   output logic [7:0]  wABD_BRSx,
   input  logic        wUCOS16
);

   localparam int TMR_W = $clog2(((BRK_MIN > DELIM_MAX) ? BRK_MIN : DELIM_MAX) + 1);

   logic [2:0]       state_q, state_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rxs_q, rxs_d;
   logic             rxs_prev_q, rxs_prev_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [2:0]       edges_q, edges_d;
   logic             brkifg_q, brkifg_d;
   logic             stoe_q, stoe_d;
   logic             done_q, done_d;
   logic [15:0]      brx_q, brx_d;
   logic [3:0]       brfx_q, brfx_d;
   logic [7:0]       brsx_q, brsx_d;

   logic             fall, rise, brk_set, stoe_set;
   logic [15:0]      calc_brx;
   logic [3:0]       calc_brfx;
   logic [7:0]       calc_brsx;
   logic             calc_err;

   abd_divisor_calc #(.CNT_W(CNT_W)) u_calc (
      .n    (n_q),
      .os16 (wUCOS16),
      .brx  (calc_brx),
      .brfx (calc_brfx),
      .brsx (calc_brsx),
      .err  (calc_err)
   );

   always_comb begin
      rx_meta_d  = UCRXD;
      rxs_d      = rx_meta_q;
      rxs_prev_d = rxs_q;
      fall       = rxs_prev_q & ~rxs_q;
      rise       = ~rxs_prev_q & rxs_q;

      state_d  = state_q;
      tmr_d    = tmr_q;
      n_d      = n_q;
      edges_d  = edges_q;
      brk_set  = 1'b0;
      stoe_set = 1'b0;
      done_d   = 1'b0;
      brx_d    = brx_q;
      brfx_d   = brfx_q;
      brsx_d   = brsx_q;

      if (!UCABDEN) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_WAIT_BRK;
            ST_WAIT_BRK: begin
               // The edge cycle is itself low, so the timer starts one short.
               if (fall) begin
                  state_d = ST_BRK;
                  tmr_d   = TMR_W'(BRK_MIN - 1);
               end
            end
            ST_BRK: begin
               if (rise) begin
                  if (tmr_q == '0) begin
                     brk_set = 1'b1;
                     state_d = ST_DELIM;
                     tmr_d   = TMR_W'(DELIM_MAX - 2);
                  end else begin
                     state_d = ST_WAIT_BRK;
                  end
               end else if (tmr_q != '0) begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            ST_DELIM: begin
               if (fall) begin
                  state_d = ST_SYNC;
                  n_d     = CNT_W'(1);
                  edges_d = 3'd1;
               end else if (tmr_q == '0) begin
                  stoe_set = 1'b1;
                  state_d  = ST_WAIT_BRK;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            ST_SYNC: begin
               // Results are registered on the final edge so they appear with ABDDone.
               if (fall && (edges_q == SYNC_EDGES - 3'd1)) begin
                  state_d = ST_DONE;
                  if (calc_err) begin
                     stoe_set = 1'b1;
                  end else begin
                     done_d = 1'b1;
                     brx_d  = calc_brx;
                     brfx_d = calc_brfx;
                     brsx_d = calc_brsx;
                  end
               end else if (n_q == '1) begin
                  stoe_set = 1'b1;
                  state_d  = ST_WAIT_BRK;
               end else begin
                  n_d = n_q + CNT_W'(1);
                  if (fall) edges_d = edges_q + 3'd1;
               end
            end
            ST_DONE: state_d = ST_WAIT_BRK;
            default: state_d = ST_IDLE;
         endcase
      end

      brkifg_d = brk_set | (brkifg_q & ~UCBRKCLR);
      stoe_d   = stoe_set | (stoe_q & ~UCSTOECLR);
   end

   always_ff @(posedge BRCLK) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         tmr_q      <= '0;
         n_q        <= '0;
         edges_q    <= '0;
         brkifg_q   <= 1'b0;
         stoe_q     <= 1'b0;
         done_q     <= 1'b0;
         brx_q      <= '0;
         brfx_q     <= '0;
         brsx_q     <= '0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx_meta_d;
         rxs_q      <= rxs_d;
         rxs_prev_q <= rxs_prev_d;
         tmr_q      <= tmr_d;
         n_q        <= n_d;
         edges_q    <= edges_d;
         brkifg_q   <= brkifg_d;
         stoe_q     <= stoe_d;
         done_q     <= done_d;
         brx_q      <= brx_d;
         brfx_q     <= brfx_d;
         brsx_q     <= brsx_d;
      end
   end

   assign UCBRKIFG  = brkifg_q;
   assign UCSTOE    = stoe_q;
   assign ABDDone   = done_q;
   assign ABDBusy   = (state_q == ST_BRK) || (state_q == ST_DELIM) || (state_q == ST_SYNC);
   assign wABD_BRx  = brx_q;
   assign wABD_BRFx = brfx_q;
   assign wABD_BRSx = brsx_q;

endmodule
